// File: rtl/router_pkt_reader.sv
// Read-side packet consumer for one router output port: drains the port FIFO,
// streams header/payload to a sink with sop/eop, checks parity, reports done/abort.
module router_pkt_reader #(
  parameter int unsigned DW    = 8,
  parameter int unsigned LEN_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld_out,
  input  logic [DW-1:0] data_out,
  input  logic          soft_reset,
  input  logic          sink_ready,
  output logic          rd_en,
  output logic [DW-1:0] pkt_data,
  output logic          pkt_valid,
  output logic          pkt_sop,
  output logic          pkt_eop,
  output logic          pkt_done,
  output logic          parity_err,
  output logic          pkt_abort,
  output logic          busy
);

  // Counters hold len+1 (payload plus parity), so they need one extra bit.
  localparam int unsigned CW = LEN_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT_HDR, STREAM, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] recv_cnt_q, recv_cnt_d;
  logic [DW-1:0] parity_acc_q, parity_acc_d;
  logic          rd_q, rd_d;
  logic [DW-1:0] pkt_data_q, pkt_data_d;
  logic          pkt_valid_q, pkt_valid_d;
  logic          pkt_sop_q, pkt_sop_d;
  logic          pkt_eop_q, pkt_eop_d;
  logic          pkt_done_q, pkt_done_d;
  logic          parity_err_q, parity_err_d;
  logic          pkt_abort_q, pkt_abort_d;
  logic [LEN_W-1:0] hdr_len;

  assign hdr_len = data_out[DW-1 -: LEN_W];

  // FIFO read strobe; sink_ready is only consulted at issue time.
  always_comb begin
    rd_en = 1'b0;
    if (rst && !soft_reset && vld_out && sink_ready) begin
      case (state_q)
        IDLE:    rd_en = 1'b1;
        STREAM:  rd_en = (issue_cnt_q != '0);
        default: rd_en = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    parity_acc_d = parity_acc_q;
    rd_d         = rd_en;
    pkt_data_d   = pkt_data_q;
    pkt_valid_d  = 1'b0;
    pkt_sop_d    = 1'b0;
    pkt_eop_d    = 1'b0;
    pkt_done_d   = 1'b0;
    parity_err_d = 1'b0;
    pkt_abort_d  = 1'b0;

    if (soft_reset && (state_q != IDLE)) begin
      // Abort: drop any returning byte and report through the DONE cycle.
      state_d     = DONE;
      pkt_done_d  = 1'b1;
      pkt_abort_d = 1'b1;
      rd_d        = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_en) state_d = WAIT_HDR;
        end
        WAIT_HDR: begin
          parity_acc_d = data_out;
          issue_cnt_d  = CW'(hdr_len) + CW'(1);
          recv_cnt_d   = CW'(hdr_len) + CW'(1);
          pkt_data_d   = data_out;
          pkt_valid_d  = 1'b1;
          pkt_sop_d    = 1'b1;
          pkt_eop_d    = (hdr_len == '0);
          state_d      = STREAM;
        end
        STREAM: begin
          if (rd_en) issue_cnt_d = issue_cnt_q - CW'(1);
          if (rd_q) begin
            recv_cnt_d = recv_cnt_q - CW'(1);
            if (recv_cnt_q > CW'(1)) begin
              pkt_data_d   = data_out;
              pkt_valid_d  = 1'b1;
              pkt_eop_d    = (recv_cnt_q == CW'(2));
              parity_acc_d = parity_acc_q ^ data_out;
            end else begin
              // Last returned byte is the parity byte; it is checked, not forwarded.
              pkt_done_d   = 1'b1;
              parity_err_d = (data_out != parity_acc_q);
              state_d      = DONE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
      parity_acc_q <= '0;
      rd_q         <= 1'b0;
      pkt_data_q   <= '0;
      pkt_valid_q  <= 1'b0;
      pkt_sop_q    <= 1'b0;
      pkt_eop_q    <= 1'b0;
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      pkt_abort_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      parity_acc_q <= parity_acc_d;
      rd_q         <= rd_d;
      pkt_data_q   <= pkt_data_d;
      pkt_valid_q  <= pkt_valid_d;
      pkt_sop_q    <= pkt_sop_d;
      pkt_eop_q    <= pkt_eop_d;
      pkt_done_q   <= pkt_done_d;
      parity_err_q <= parity_err_d;
      pkt_abort_q  <= pkt_abort_d;
    end
  end

  assign pkt_data   = pkt_data_q;
  assign pkt_valid  = pkt_valid_q;
  assign pkt_sop    = pkt_sop_q;
  assign pkt_eop    = pkt_eop_q;
  assign pkt_done   = pkt_done_q;
  assign parity_err = parity_err_q;
  assign pkt_abort  = pkt_abort_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_router_pkt_reader.sv
// Scoreboard bench for router_pkt_reader: FIFO model feeds packets, a monitor
// compares every streamed byte and completion report against expected queues.
module tb_router_pkt_reader;
  localparam int unsigned DW    = 8;
  localparam int unsigned LEN_W = 6;

  typedef struct packed {logic [7:0] data; logic sop; logic eop;} byte_t;
  typedef struct packed {logic err; logic abort;} done_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic vld_out = 1'b0;
  logic [DW-1:0] data_out = '0;
  logic soft_reset = 1'b0;
  logic sink_ready = 1'b0;
  logic rd_en, pkt_valid, pkt_sop, pkt_eop, pkt_done, parity_err, pkt_abort, busy;
  logic [DW-1:0] pkt_data;

  router_pkt_reader #(.DW(DW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .vld_out(vld_out), .data_out(data_out),
    .soft_reset(soft_reset), .sink_ready(sink_ready), .rd_en(rd_en),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_sop(pkt_sop),
    .pkt_eop(pkt_eop), .pkt_done(pkt_done), .parity_err(parity_err),
    .pkt_abort(pkt_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo[$];
  byte_t exp_b[$];
  done_t exp_d[$];
  int hdr_cyc[$];
  int done_cyc[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Output FIFO model: one-cycle read latency, flushed by hard or soft reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst || soft_reset) begin
      fifo.delete();
      vld_out <= 1'b0;
    end else begin
      if (rd_en && fifo.size() != 0) data_out <= fifo.pop_front();
      vld_out <= (fifo.size() != 0);
    end
  end

  // Monitor: compare whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (rd_en) begin
        rd_cnt++;
        if (!busy) hdr_cyc.push_back(cyc);
      end
      if (pkt_valid) begin
        byte_t got, e;
        seen++;
        got = '{pkt_data, pkt_sop, pkt_eop};
        if (exp_b.size() == 0) check("unexpected_byte", 32'(got), 32'h3ff);
        else begin
          e = exp_b.pop_front();
          check("byte{data,sop,eop}", 32'(got), 32'(e));
        end
      end
      if (pkt_done) begin
        done_t got, e;
        done_cyc.push_back(cyc);
        got = '{parity_err, pkt_abort};
        if (exp_d.size() == 0) check("unexpected_done", 32'(got), 32'h7);
        else begin
          e = exp_d.pop_front();
          check("done{err,abort}", 32'(got), 32'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference packet builder: header {len,addr}, payload, XOR parity.
  task automatic push_pkt(input logic [7:0] pl[$], input logic [1:0] addr, input bit bad);
    logic [7:0] h, par;
    int n;
    n = pl.size();
    h = {6'(n), addr};
    par = h;
    fifo.push_back(h);
    exp_b.push_back('{h, 1'b1, n == 0});
    for (int i = 0; i < n; i++) begin
      par = par ^ pl[i];
      fifo.push_back(pl[i]);
      exp_b.push_back('{pl[i], 1'b0, i == n - 1});
    end
    fifo.push_back(bad ? (par ^ 8'h01) : par);
    exp_d.push_back('{bad, 1'b0});
  endtask

  task automatic push_rand(input int len, input bit bad);
    logic [7:0] pl[$];
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
    push_pkt(pl, 2'($urandom), bad);
  endtask

  task automatic wait_idle(input string name, input bit rnd);
    int i;
    i = 0;
    while ((exp_b.size() != 0 || exp_d.size() != 0 || fifo.size() != 0 || busy) && i < 3000) begin
      sink_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      i++;
    end
    sink_ready = 1'b1;
    tick();
    tick();
    if (i >= 3000) check({name, "_timeout"}, 32'(i), 32'd0);
  endtask

  task automatic wait_seen(input string name, input int target);
    int i;
    i = 0;
    while (seen < target && i < 200) begin
      tick();
      i++;
    end
    if (i >= 200) check({name, "_wait_timeout"}, 32'(seen), 32'(target));
  endtask

  task automatic lat(input string name, input int exp);
    if (hdr_cyc.size() == 0 || done_cyc.size() == 0)
      check({name, "_no_events"}, 32'(done_cyc.size()), 32'd1);
    else
      check(name, 32'(done_cyc[0] - hdr_cyc[0]), 32'(exp));
    hdr_cyc.delete();
    done_cyc.delete();
  endtask

  initial begin
    logic [7:0] pl[$];
    int base;

    repeat (3) tick();
    check("reset_outputs", 32'({rd_en, pkt_valid, pkt_sop, pkt_eop, pkt_done,
                                parity_err, pkt_abort, busy, pkt_data}), 32'd0);
    rst = 1'b1;
    sink_ready = 1'b1;
    tick();
    hdr_cyc.delete();
    done_cyc.delete();

    pl = '{8'hA1, 8'hB2, 8'hC3};
    push_pkt(pl, 2'd1, 1'b0);
    wait_idle("good", 1'b0);
    lat("good_done_latency", 7);

    push_pkt(pl, 2'd1, 1'b1);
    wait_idle("bad_parity", 1'b0);
    lat("bad_done_latency", 7);

    pl.delete();
    push_pkt(pl, 2'd2, 1'b0);
    wait_idle("zero_len", 1'b0);
    lat("zero_done_latency", 4);

    // Sink stall after the first payload read.
    pl = '{8'hA1, 8'hB2, 8'hC3};
    base = rd_cnt;
    push_pkt(pl, 2'd1, 1'b0);
    for (int i = 0; i < 200 && rd_cnt < base + 2; i++) tick();
    sink_ready = 1'b0;
    repeat (5) tick();
    check("stall_no_reads", 32'(rd_cnt), 32'(base + 2));
    sink_ready = 1'b1;
    wait_idle("stall", 1'b0);
    lat("stall_done_latency", 12);

    // Soft reset after two payload bytes of a len=10 packet.
    base = seen;
    push_rand(10, 1'b0);
    wait_seen("soft", base + 3);
    soft_reset = 1'b1;
    exp_d.delete();
    exp_d.push_back('{1'b0, 1'b1});
    #1;
    check("soft_rd_en_low", 32'(rd_en), 32'd0);
    tick();
    soft_reset = 1'b0;
    exp_b.delete();
    check("soft_valid_low", 32'(pkt_valid), 32'd0);
    check("soft_done_abort", 32'({pkt_done, pkt_abort, parity_err}), 32'b110);
    wait_idle("soft", 1'b0);
    push_rand(4, 1'b0);
    wait_idle("after_soft", 1'b0);
    hdr_cyc.delete();
    done_cyc.delete();

    // Hard reset while streaming.
    base = seen;
    push_rand(8, 1'b0);
    wait_seen("hard", base + 2);
    rst = 1'b0;
    tick();
    check("hard_reset_outputs", 32'({rd_en, pkt_valid, pkt_sop, pkt_eop, pkt_done,
                                     parity_err, pkt_abort, busy, pkt_data}), 32'd0);
    exp_b.delete();
    exp_d.delete();
    tick();
    rst = 1'b1;
    wait_idle("hard", 1'b0);
    hdr_cyc.delete();
    done_cyc.delete();

    // Back-to-back packets.
    push_rand(2, 1'b0);
    push_rand(0, 1'b0);
    wait_idle("b2b", 1'b0);
    if (hdr_cyc.size() < 2 || done_cyc.size() < 1)
      check("b2b_events", 32'(hdr_cyc.size()), 32'd2);
    else
      check("b2b_second_hdr_cycle", 32'(hdr_cyc[1]), 32'(done_cyc[0] + 1));
    hdr_cyc.delete();
    done_cyc.delete();

    // Random traffic with sink stalls, including maximum length.
    for (int p = 0; p < 40; p++) begin
      push_rand((p % 13 == 0) ? 63 : int'($urandom_range(0, 12)), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 6)) begin
        sink_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    wait_idle("random", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
